aes_mode_ctrl: RTL and testbench

AES_MODE_CTRL -- requirements
Module: aes_mode_ctrl

---
 rtl/aes_mode_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_aes_mode_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_mode_ctrl.sv
// AES block-mode controller: per-channel ECB/CBC/CTR contexts wrapped around an external AES core.
// One block is in flight at a time; the chaining value is committed on the output handshake.
module aes_mode_ctrl #(
    parameter int unsigned CH_NUM = 4,
    parameter int unsigned CTR_W  = 32
) (
    input  logic                      HCLK,
    input  logic                      rst,
    input  logic                      cfg_valid,
    input  logic [$clog2(CH_NUM)-1:0] cfg_ch,
    input  logic [1:0]                cfg_mode,
    input  logic [127:0]              cfg_key,
    input  logic [127:0]              cfg_iv,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [$clog2(CH_NUM)-1:0] in_ch,
    input  logic                      in_encrypt,
    input  logic                      in_last,
    input  logic [127:0]              in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(CH_NUM)-1:0] out_ch,
    output logic [127:0]              out_data,
    output logic                      core_start,
    output logic                      core_encrypt,
    output logic [127:0]              core_key,
    output logic [127:0]              core_data,
    input  logic                      core_done,
    input  logic [127:0]              core_result,
    output logic                      err
);

    localparam int unsigned CH_W  = $clog2(CH_NUM);
    localparam int unsigned BLK_W = 128;
    localparam logic [1:0] MODE_CBC = 2'b01;
    localparam logic [1:0] MODE_CTR = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_OUT} state_e;

    state_e state_q, state_d;

    logic [BLK_W-1:0] key_q   [CH_NUM];
    logic [BLK_W-1:0] key_d   [CH_NUM];
    logic [BLK_W-1:0] iv_q    [CH_NUM];
    logic [BLK_W-1:0] iv_d    [CH_NUM];
    logic [BLK_W-1:0] chain_q [CH_NUM];
    logic [BLK_W-1:0] chain_d [CH_NUM];
    logic [1:0]       mode_q  [CH_NUM];
    logic [1:0]       mode_d  [CH_NUM];
    logic [CH_NUM-1:0] cfgd_q, cfgd_d;

    logic [CH_W-1:0]  cur_ch_q, cur_ch_d;
    logic [1:0]       cur_mode_q, cur_mode_d;
    logic             cur_last_q, cur_last_d;
    logic [BLK_W-1:0] cur_data_q, cur_data_d;
    logic [BLK_W-1:0] cur_chain_q, cur_chain_d;

    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [CH_W-1:0]  out_ch_q, out_ch_d;
    logic [BLK_W-1:0] out_data_q, out_data_d;
    logic             core_start_q, core_start_d;
    logic             core_encrypt_q, core_encrypt_d;
    logic [BLK_W-1:0] core_key_q, core_key_d;
    logic [BLK_W-1:0] core_data_q, core_data_d;
    logic             err_q, err_d;

    logic in_hs, blk_ok, blk_err, cfg_rej, cfg_ok, out_hs;

    function automatic logic [BLK_W-1:0] ctr_inc(input logic [BLK_W-1:0] c);
        ctr_inc = {c[BLK_W-1:CTR_W], c[CTR_W-1:0] + CTR_W'(1)};
    endfunction

    // Handshake and config acceptance decode
    always_comb begin
        in_hs   = in_valid && in_ready_q;
        blk_ok  = in_hs && cfgd_q[in_ch];
        blk_err = in_hs && !cfgd_q[in_ch];
        cfg_rej = cfg_valid && ((cfg_mode == MODE_RSV) ||
                                ((state_q != S_IDLE) && (cfg_ch == cur_ch_q)));
        cfg_ok  = cfg_valid && !cfg_rej;
        out_hs  = out_valid_q && out_ready;
    end

    always_ff @(posedge HCLK) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (blk_ok)    state_d = S_LAUNCH;
            S_LAUNCH:                state_d = S_WAIT;
            S_WAIT:   if (core_done) state_d = S_OUT;
            S_OUT:    if (out_hs)    state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    always_comb begin
        key_d          = key_q;
        iv_d           = iv_q;
        chain_d        = chain_q;
        mode_d         = mode_q;
        cfgd_d         = cfgd_q;
        cur_ch_d       = cur_ch_q;
        cur_mode_d     = cur_mode_q;
        cur_last_d     = cur_last_q;
        cur_data_d     = cur_data_q;
        cur_chain_d    = cur_chain_q;
        out_ch_d       = out_ch_q;
        out_data_d     = out_data_q;
        core_encrypt_d = core_encrypt_q;
        core_key_d     = core_key_q;
        core_data_d    = core_data_q;
        in_ready_d     = (state_d == S_IDLE);
        out_valid_d    = (state_d == S_OUT);
        core_start_d   = (state_d == S_LAUNCH);
        err_d          = cfg_rej || blk_err;

        // Chaining commit; end of message rewinds to the stored IV
        if (out_hs) begin
            if (cur_last_q) begin
                chain_d[cur_ch_q] = iv_q[cur_ch_q];
            end else begin
                case (cur_mode_q)
                    MODE_CBC: chain_d[cur_ch_q] = core_encrypt_q ? out_data_q : cur_data_q;
                    MODE_CTR: chain_d[cur_ch_q] = ctr_inc(cur_chain_q);
                    default: ;
                endcase
            end
        end

        // Capture the pre-write context so a same-cycle config cannot disturb this block
        if (blk_ok) begin
            cur_ch_d    = in_ch;
            cur_mode_d  = mode_q[in_ch];
            cur_last_d  = in_last;
            cur_data_d  = in_data;
            cur_chain_d = chain_q[in_ch];
            core_key_d  = key_q[in_ch];
            case (mode_q[in_ch])
                MODE_CBC: begin
                    core_encrypt_d = in_encrypt;
                    core_data_d    = in_encrypt ? (in_data ^ chain_q[in_ch]) : in_data;
                end
                MODE_CTR: begin
                    core_encrypt_d = 1'b1;
                    core_data_d    = chain_q[in_ch];
                end
                default: begin
                    core_encrypt_d = in_encrypt;
                    core_data_d    = in_data;
                end
            endcase
        end

        if ((state_q == S_WAIT) && core_done) begin
            out_ch_d = cur_ch_q;
            case (cur_mode_q)
                MODE_CBC: out_data_d = core_encrypt_q ? core_result : (core_result ^ cur_chain_q);
                MODE_CTR: out_data_d = cur_data_q ^ core_result;
                default:  out_data_d = core_result;
            endcase
        end

        if (cfg_ok) begin
            key_d[cfg_ch]   = cfg_key;
            iv_d[cfg_ch]    = cfg_iv;
            mode_d[cfg_ch]  = cfg_mode;
            chain_d[cfg_ch] = cfg_iv;
            cfgd_d[cfg_ch]  = 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (rst) begin
            for (int i = 0; i < int'(CH_NUM); i++) begin
                key_q[i]   <= '0;
                iv_q[i]    <= '0;
                chain_q[i] <= '0;
                mode_q[i]  <= '0;
            end
            cfgd_q         <= '0;
            cur_ch_q       <= '0;
            cur_mode_q     <= '0;
            cur_last_q     <= 1'b0;
            cur_data_q     <= '0;
            cur_chain_q    <= '0;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            out_ch_q       <= '0;
            out_data_q     <= '0;
            core_start_q   <= 1'b0;
            core_encrypt_q <= 1'b0;
            core_key_q     <= '0;
            core_data_q    <= '0;
            err_q          <= 1'b0;
        end else begin
            key_q          <= key_d;
            iv_q           <= iv_d;
            chain_q        <= chain_d;
            mode_q         <= mode_d;
            cfgd_q         <= cfgd_d;
            cur_ch_q       <= cur_ch_d;
            cur_mode_q     <= cur_mode_d;
            cur_last_q     <= cur_last_d;
            cur_data_q     <= cur_data_d;
            cur_chain_q    <= cur_chain_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            out_ch_q       <= out_ch_d;
            out_data_q     <= out_data_d;
            core_start_q   <= core_start_d;
            core_encrypt_q <= core_encrypt_d;
            core_key_q     <= core_key_d;
            core_data_q    <= core_data_d;
            err_q          <= err_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_ch       = out_ch_q;
    assign out_data     = out_data_q;
    assign core_start   = core_start_q;
    assign core_encrypt = core_encrypt_q;
    assign core_key     = core_key_q;
    assign core_data    = core_data_q;
    assign err          = err_q;

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Bench for aes_mode_ctrl: the bench plays the AES core and tracks channel contexts in a reference model.
module tb_aes_mode_ctrl;

    localparam logic [127:0] K_VEC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_VEC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_VEC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] MAGIC = 128'ha5a5_5a5a_c3c3_3c3c_0f0f_f0f0_9696_6969;

    logic         HCLK = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic [1:0]   cfg_ch = '0;
    logic [1:0]   cfg_mode = '0;
    logic [127:0] cfg_key = '0;
    logic [127:0] cfg_iv = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_ch = '0;
    logic         in_encrypt = 1'b0;
    logic         in_last = 1'b0;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [1:0]   out_ch;
    logic [127:0] out_data;
    logic         core_start;
    logic         core_encrypt;
    logic [127:0] core_key;
    logic [127:0] core_data;
    logic         core_done = 1'b0;
    logic [127:0] core_result = '0;
    logic         err;

    aes_mode_ctrl #(.CH_NUM(4), .CTR_W(32)) dut (
        .HCLK(HCLK), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_encrypt(in_encrypt),
        .in_last(in_last), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
        .core_start(core_start), .core_encrypt(core_encrypt), .core_key(core_key),
        .core_data(core_data), .core_done(core_done), .core_result(core_result),
        .err(err)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    // Reference model: per-channel context plus the captured in-flight block
    bit           m_cfg   [4];
    logic [1:0]   m_mode  [4];
    logic [127:0] m_key   [4];
    logic [127:0] m_iv    [4];
    logic [127:0] m_chain [4];
    bit           busy;
    logic [1:0]   busy_ch;
    logic [1:0]   c_mode;
    bit           c_last, c_enc;
    logic [127:0] c_data, c_chain, c_key, exp_cd;
    bit           exp_ce;
    logic [127:0] obs_cd, obs_out;
    bit           obs_ce;

    typedef struct {
        bit           do_cfg;
        logic [1:0]   ch;
        logic [1:0]   mode;
        logic [127:0] key;
        logic [127:0] iv;
        bit           enc;
        bit           last;
        logic [127:0] data;
        int           hold;
        logic [127:0] exp_core_data;
        bit           exp_core_enc;
        logic [127:0] exp_out;
    } vec_t;

    vec_t tbl [7];

    // Stand-in cipher: the published AES-128 vector pair, otherwise an invertible keyed mix
    function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] d, input bit enc);
        logic [127:0] x;
        if (enc && k == K_VEC && d == P_VEC) return C_VEC;
        if (!enc && k == K_VEC && d == C_VEC) return P_VEC;
        if (enc) begin
            x = d ^ k;
            return {x[114:0], x[127:115]} ^ MAGIC;
        end
        x = d ^ MAGIC;
        return {x[12:0], x[127:13]} ^ k;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cfg[i] = 0; m_mode[i] = '0; m_key[i] = '0; m_iv[i] = '0; m_chain[i] = '0;
        end
        busy = 0;
    endtask

    task automatic do_cfg(input logic [1:0] ch, input logic [1:0] mode,
                          input logic [127:0] key, input logic [127:0] iv);
        bit rej;
        rej = (mode == 2'b11) || (busy && ch == busy_ch);
        cfg_valid = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_key = key; cfg_iv = iv;
        tick();
        cfg_valid = 1'b0;
        chk("cfg_err", err, rej);
        if (rej) chk("cfg_rej_no_start", core_start, 0);
        else begin
            m_cfg[ch] = 1; m_mode[ch] = mode; m_key[ch] = key; m_iv[ch] = iv; m_chain[ch] = iv;
        end
    endtask

    task automatic start_block(input logic [1:0] ch, input bit enc, input bit last,
                               input logic [127:0] data, output bit ok);
        int n = 0;
        ok = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1 within 20 cycles");
            return;
        end
        in_valid = 1'b1; in_ch = ch; in_encrypt = enc; in_last = last; in_data = data;
        tick();
        in_valid = 1'b0;
        if (!m_cfg[ch]) begin
            chk("blk_unconf_err", err, 1);
            chk("blk_unconf_no_start", core_start, 0);
            chk("blk_unconf_idle", in_ready, 1);
            return;
        end
        c_mode = m_mode[ch]; c_last = last; c_enc = enc; c_data = data;
        c_chain = m_chain[ch]; c_key = m_key[ch];
        case (c_mode)
            2'b01:   begin exp_ce = enc; exp_cd = enc ? (data ^ c_chain) : data; end
            2'b10:   begin exp_ce = 1;   exp_cd = c_chain; end
            default: begin exp_ce = enc; exp_cd = data; end
        endcase
        chk("blk_no_err", err, 0);
        chk("core_start", core_start, 1);
        chk("in_ready_busy", in_ready, 0);
        chk("core_key", core_key, c_key);
        chk("core_encrypt", core_encrypt, exp_ce);
        chk("core_data", core_data, exp_cd);
        obs_cd = core_data; obs_ce = core_encrypt;
        busy = 1; busy_ch = ch;
        ok = 1;
    endtask

    task automatic finish_block(input int lat, input int hold, input bit mid_cfg);
        logic [127:0] res, exp_out, nxt;
        tick();
        chk("start_pulse_end", core_start, 0);
        chk("core_data_hold", core_data, exp_cd);
        for (int i = 0; i < lat; i++) begin
            if (mid_cfg && i == 0)
                do_cfg(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rnd128(), rnd128());
            else
                tick();
            chk("no_out_early", out_valid, 0);
        end
        res = cipher(c_key, exp_cd, exp_ce);
        core_done = 1'b1; core_result = res;
        tick();
        core_done = 1'b0; core_result = rnd128();
        case (c_mode)
            2'b01:   exp_out = c_enc ? res : (res ^ c_chain);
            2'b10:   exp_out = c_data ^ res;
            default: exp_out = res;
        endcase
        chk("out_valid", out_valid, 1);
        chk("out_ch", out_ch, busy_ch);
        chk("out_data", out_data, exp_out);
        obs_out = out_data;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, exp_out);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        chk("back_idle", in_ready, 1);
        if (c_last) nxt = m_iv[busy_ch];
        else if (c_mode == 2'b01) nxt = c_enc ? res : c_data;
        else if (c_mode == 2'b10) nxt = {c_chain[127:32], c_chain[31:0] + 32'd1};
        else nxt = c_chain;
        m_chain[busy_ch] = nxt;
        busy = 0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [127:0] iv_ctr, ctr2;
        iv_ctr = {96'h0123456789abcdef_fedcba98, 32'hffffffff};
        ctr2   = {iv_ctr[127:32], 32'h00000000};

        tbl[0] = '{1, 2'd0, 2'b00, K_VEC, '0, 1, 0, P_VEC, 0, P_VEC, 1, C_VEC};
        tbl[1] = '{0, 2'd0, 2'b00, '0, '0, 0, 0, C_VEC, 5, C_VEC, 0, P_VEC};
        tbl[2] = '{1, 2'd1, 2'b01, K_VEC, '0, 1, 0, P_VEC, 0, P_VEC, 1, C_VEC};
        tbl[3] = '{0, 2'd1, 2'b01, '0, '0, 1, 1, P_VEC, 1, P_VEC ^ C_VEC, 1, cipher(K_VEC, P_VEC ^ C_VEC, 1)};
        tbl[4] = '{0, 2'd1, 2'b01, '0, '0, 1, 0, P_VEC, 0, P_VEC, 1, C_VEC};
        tbl[5] = '{1, 2'd2, 2'b10, K_VEC, iv_ctr, 0, 0, P_VEC, 0, iv_ctr, 1, P_VEC ^ cipher(K_VEC, iv_ctr, 1)};
        tbl[6] = '{0, 2'd2, 2'b10, '0, '0, 1, 0, P_VEC, 2, ctr2, 1, P_VEC ^ cipher(K_VEC, ctr2, 1)};

        model_reset();
        @(negedge HCLK);
        tick(); tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_err", err, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_core_key", core_key, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

        // Unconfigured channel and reserved mode are both refused
        start_block(2'd3, 1, 0, P_VEC, ok);
        do_cfg(2'd1, 2'b11, K_VEC, '0);
        start_block(2'd1, 1, 0, P_VEC, ok);

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].do_cfg) do_cfg(tbl[i].ch, tbl[i].mode, tbl[i].key, tbl[i].iv);
            start_block(tbl[i].ch, tbl[i].enc, tbl[i].last, tbl[i].data, ok);
            if (ok) begin
                finish_block(1, tbl[i].hold, 0);
                chk("tbl_core_data", obs_cd, tbl[i].exp_core_data);
                chk("tbl_core_enc", obs_ce, tbl[i].exp_core_enc);
                chk("tbl_out", obs_out, tbl[i].exp_out);
            end else begin
                chk("tbl_accepted", ok, 1);
            end
        end

        // Config to the in-flight channel is refused, to another channel it lands
        start_block(2'd0, 1, 0, P_VEC, ok);
        if (ok) begin
            do_cfg(2'd0, 2'b00, rnd128(), rnd128());
            do_cfg(2'd3, 2'b01, rnd128(), rnd128());
            finish_block(1, 0, 0);
        end
        start_block(2'd0, 1, 0, P_VEC, ok);
        if (ok) finish_block(0, 0, 0);
        start_block(2'd3, 1, 0, rnd128(), ok);
        if (ok) finish_block(2, 1, 0);

        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 9) < 3) begin
                logic [127:0] iv;
                iv = rnd128();
                if ($urandom_range(0, 1) == 1) iv[31:0] = 32'hffffffff - 32'($urandom_range(0, 2));
                do_cfg(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rnd128(), iv);
            end else begin
                start_block(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 3) == 0), rnd128(), ok);
                if (ok) finish_block($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            end
        end

        // Reset while waiting on the core; the late done must be ignored
        do_cfg(2'd0, 2'b00, K_VEC, '0);
        start_block(2'd0, 1, 0, P_VEC, ok);
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_core_start", core_start, 0);
        chk("mid_rst_core_enc", core_encrypt, 0);
        chk("mid_rst_core_key", core_key, 0);
        chk("mid_rst_core_data", core_data, 0);
        chk("mid_rst_out_ch", out_ch, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_err", err, 0);
        rst = 1'b0;
        core_done = 1'b1; core_result = C_VEC;
        tick();
        core_done = 1'b0;
        model_reset();
        chk("late_done_no_out", out_valid, 0);
        chk("late_done_idle", in_ready, 1);
        tick(); tick();
        chk("late_done_still_no_out", out_valid, 0);
        start_block(2'd0, 1, 0, P_VEC, ok);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
